// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } mem_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [3:0] REG_PC  = 4'hF;

  // Memory-stage result beats writeback; the PC register is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic [3:0] wa_m,
                                         input logic [3:0] wa_w,
                                         input logic       we_m,
                                         input logic       we_w);
    if (ra == REG_PC)
      return FWD_RF;
    else if (we_m && (wa_m == ra))
      return FWD_MEM;
    else if (we_w && (wa_w == ra))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Multi-cycle data-memory wait sequencer with timeout abort and sticky timeout flag.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ack,
  output logic mem_busy,
  output logic abort,
  output logic mem_timeout
);

  mem_state_t state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       timeout_reg, timeout_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  // The request cycle in IDLE already stalls, so it counts as the first wait cycle.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    mem_busy      = 1'b0;
    abort         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_req && !mem_ack) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
          mem_busy      = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == 8'(MEM_TIMEOUT - 1)) begin
          state_next    = ABORT;
          wait_cnt_next = '0;
          timeout_next  = 1'b1;
          mem_busy      = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          mem_busy      = 1'b1;
        end
      end
      ABORT: begin
        abort      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  assign mem_timeout = timeout_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, control flush, memory freeze, perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic mem_busy, mem_abort;
  logic ldrstall, pcpend;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (MemReqM),
    .mem_ack    (MemAckM),
    .mem_busy   (mem_busy),
    .abort      (mem_abort),
    .mem_timeout(MemTimeout)
  );

  assign ldrstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign pcpend   = PCSrcD | PCSrcE | PCSrcM;

  // A memory freeze holds every stage, so pending branch/load-use work resumes after release.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_sel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
      ForwardBE = fwd_sel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
      if (mem_busy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = ldrstall | pcpend;
        StallD = ldrstall;
        FlushD = pcpend | PCSrcW | BranchTakenE;
        FlushE = ldrstall | BranchTakenE;
        FlushW = mem_abort;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (StallF && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (FlushE && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign StallCount = stall_cnt_reg;
  assign FlushCount = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemAckM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [3:0] StallCount, FlushCount;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [19:0] v;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_sc = 4'd0;
  logic [3:0] exp_fc = 4'd0;

  task automatic clr();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd9; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  // st = {StallF,StallD,StallE,StallM}, fl = {FlushD,FlushE,FlushW}
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] st, input logic [2:0] fl, input logic mto);
    exp_t        e;
    exp_t        got;
    logic [19:0] obs;
    e.tag = tag;
    e.v   = {fa, fb, st, fl, mto, exp_sc, exp_fc};
    sbq.push_back(e);
    @(negedge clk);
    obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemTimeout, StallCount, FlushCount};
    got = sbq.pop_front();
    checks++;
    $display("step %-12s obs=%05h exp=%05h", got.tag, obs, got.v);
    assert (obs === got.v) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", got.tag, obs, got.v);
    end
    @(posedge clk);
    if (reset) begin
      exp_sc = 4'd0;
      exp_fc = 4'd0;
    end else begin
      if (st[3] && exp_sc != 4'hF) exp_sc = exp_sc + 4'd1;
      if (fl[1] && exp_fc != 4'hF) exp_fc = exp_fc + 4'd1;
    end
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; BranchTakenE = 1'b1;
    @(posedge clk); #1;
    step("rst_a", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    step("rst_b", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    reset = 1'b0; clr();
    step("idle", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd5;
    step("fwd_m_win", 2'b10, 2'b00, 4'b0000, 3'b000, 1'b0);
    RegWriteM = 1'b0;
    step("fwd_w", 2'b01, 2'b00, 4'b0000, 3'b000, 1'b0);
    RegWriteM = 1'b1; WA3M = 4'd15; WA3W = 4'd15; RA1E = 4'd15;
    step("fwd_r15", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    WA3M = 4'd5; RA1E = 4'd7;
    step("fwd_b_m", 2'b00, 2'b10, 4'b0000, 3'b000, 1'b0);
    clr();

    MemtoRegE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd6;
    step("ldr", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0);
    clr();
    step("ldr_after", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    BranchTakenE = 1'b1;
    step("br", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0);
    clr();
    step("br_after", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    PCSrcD = 1'b1;
    step("pcsrcd", 2'b00, 2'b00, 4'b1000, 3'b100, 1'b0);
    clr();
    MemtoRegE = 1'b1; WA3E = 4'd4; RA1D = 4'd4; BranchTakenE = 1'b1;
    step("ldr_br", 2'b00, 2'b00, 4'b1100, 3'b110, 1'b0);
    clr();
    PCSrcW = 1'b1;
    step("pcsrcw", 2'b00, 2'b00, 4'b0000, 3'b100, 1'b0);
    clr();

    MemReqM = 1'b1;
    step("mw_1", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    BranchTakenE = 1'b1;
    step("mw_2_br", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    BranchTakenE = 1'b0;
    step("mw_3", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    MemAckM = 1'b1;
    step("mw_ack", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    step("zero_wait", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    clr();

    MemReqM = 1'b1;
    step("rw_1", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    step("rw_2", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    step("rw_3", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    reset = 1'b1;
    step("rw_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
    reset = 1'b0; clr();
    step("rw_post", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    MemReqM = 1'b1;
    for (int i = 0; i < 4; i++)
      step("to_wait", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
    MemReqM = 1'b0;
    step("to_abort", 2'b00, 2'b00, 4'b0000, 3'b001, 1'b1);
    step("to_sticky", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1);

    MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
    for (int i = 0; i < 20; i++)
      step("sat", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b1);
    clr();
    step("sat_hold", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1);
    reset = 1'b1;
    step("fin_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1);
    reset = 1'b0;
    step("fin_clear", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage core. Drives the stall/clear inputs of the F/D, D/E, E/M and M/W pipeline registers and the operand-forwarding muxes in Execute. Resolves RAW hazards by forwarding, load-use hazards by a one-cycle stall, and control hazards (PC writes, taken branches) by flushing. Sequences multi-cycle data-memory accesses through a wait FSM with a timeout, and keeps saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before abort; legal range 2..255
CNT_W, 16, width of performance counters

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
RA1D, RA2D  in  4  Decode source register addresses
RA1E, RA2E  in  4  Execute source register addresses
WA3E, WA3M, WA3W  in  4  destination register in E/M/W
RegWriteM, RegWriteW  in  1  register write enable in M/W
MemtoRegE  in  1  load instruction in Execute
PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction writes PC, per stage
BranchTakenE  in  1  branch resolved taken in Execute
MemReqM  in  1  load/store active in Memory stage
MemAckM  in  1  data memory completes access this cycle
ForwardAE, ForwardBE  out  2  SrcA/SrcB select: 00 regfile, 01 W result, 10 M ALU result
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushW  out  1  clear stage register (bubble)
MemTimeout  out  1  sticky: memory access aborted by timeout
StallCount, FlushCount  out  CNT_W  performance counters

Behaviour:
- Clock clk; reset synchronous, active-high. While reset high: FSM to IDLE, wait counter 0, StallCount/FlushCount 0, MemTimeout 0; all stall/flush/forward outputs forced 0.
- Forwarding (combinational, per operand, shown for A): 10 if RegWriteM && WA3M==RA1E && RA1E!=4'hF; else 01 if RegWriteW && WA3W==RA1E && RA1E!=4'hF; else 00. M beats W when both match. R15 never forwarded.
- ldrstall = MemtoRegE && (WA3E==RA1D || WA3E==RA2D). pcpend = PCSrcD|PCSrcE|PCSrcM.
- Wait FSM (mem_busy combinational from state+inputs):
  IDLE: MemReqM && !MemAckM -> MEM_WAIT, mem_busy=1 this cycle; else mem_busy=0.
  MEM_WAIT: mem_busy=1, wait counter +1 per cycle. MemAckM -> IDLE, mem_busy=0 that cycle, counter cleared. Counter == MEM_TIMEOUT-1 without ack -> ABORT.
  ABORT: mem_busy=0, MemTimeout set (sticky until reset), FlushW=1 (aborted result discarded), -> IDLE next cycle.
  MemReqM && MemAckM in IDLE: zero-wait access, no stall.
- Priority (combinational, same cycle):
  mem_busy=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (freeze dominates; pending branch/load-use handled after release since stages held).
  else: StallF = ldrstall|pcpend; StallD = ldrstall; StallE=StallM=0; FlushD = pcpend|PCSrcW|BranchTakenE; FlushE = ldrstall|BranchTakenE; FlushW = ABORT state.
- ldrstall and BranchTakenE together: FlushE=1, StallD=1, FlushD=1.
- Counters registered: StallCount +1 each cycle StallF=1; FlushCount +1 each cycle FlushE=1; both saturate at all-ones, no wrap.
- Reset mid-MEM_WAIT: returns to IDLE next edge; no MemTimeout.

Decomposition:
- Package hazard_pkg: mem_state_t enum {IDLE, MEM_WAIT, ABORT}; FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; REG_PC=4'hF.
- Sub-module mem_wait_fsm (state, wait counter, mem_busy, abort, MemTimeout); top holds forwarding, priority logic and counters.

Test Plan:
- RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3, RA2E=5 -> ForwardAE=10, ForwardBE=00; RA1E=15 with WA3M=15 -> ForwardAE=00.
- MemtoRegE=1, WA3E=2, RA2D=2 -> StallF=1, StallD=1, FlushE=1 for exactly that cycle; StallCount 0->1.
- BranchTakenE=1 -> FlushD=1, FlushE=1, FlushCount +1; PCSrcD=1 alone -> StallF=1, FlushD=1, FlushE=0.
- MemReqM=1, MemAckM low 3 cycles then high -> Stall{F,D,E,M}=1 and FlushW=1 for 3 cycles, all 0 on ack cycle, FSM IDLE.
- MEM_TIMEOUT=4, MemReqM=1, MemAckM=0 forever -> 4 stall cycles, ABORT cycle with FlushW=1, MemTimeout=1 held until reset.
- CNT_W=4, ldrstall held 20 cycles -> StallCount saturates at 15; reset during MEM_WAIT -> all outputs 0, counters 0.
